// File: rtl/pc_fetch_controller.sv
// pc_fetch_controller
//   Computes PC_next for an enable-less Program_Counter every cycle:
//   sequential advance, branch/jump redirects (live or pending), and hold
//   while the I-cache misses or the pipeline is stalled.
//
// Ports
//   clk_i            system clock, rising edge
//   rst_ni           asynchronous active-low reset
//   pc_i             current PC (fed back from Program_Counter)
//   icache_hit_i     I-cache has a valid instruction for pc_i this cycle
//   stall_ext_i      downstream stall, fetch must not advance
//   branch_taken_i   resolved taken branch, target on branch_target_i
//   branch_target_i  branch target address
//   jump_i           resolved JAL/JALR, target on jump_target_i
//   jump_target_i    jump target address
//   pc_next_o        next PC -> Program_Counter.PC_next
//   icache_req_o     fetch request for pc_i
//   fetch_valid_o    instruction at pc_i accepted into decode this cycle
//   misalign_err_o   pulse: applied target had bits[1:0] != 0
//   miss_cnt_o       saturating count of I-cache misses since reset
module pc_fetch_controller #(
    parameter int unsigned            N_Bits       = 32,
    parameter logic [N_Bits-1:0]      RESET_VECTOR = '0,
    parameter int unsigned            CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N_Bits-1:0] pc_i,
    input  logic              icache_hit_i,
    input  logic              stall_ext_i,
    input  logic              branch_taken_i,
    input  logic [N_Bits-1:0] branch_target_i,
    input  logic              jump_i,
    input  logic [N_Bits-1:0] jump_target_i,
    output logic [N_Bits-1:0] pc_next_o,
    output logic              icache_req_o,
    output logic              fetch_valid_o,
    output logic              misalign_err_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, MISS = 2'd2} state_e;

    state_e              state_q, state_d;
    logic                pend_valid_q, pend_valid_d;
    logic [N_Bits-1:0]   pend_target_q, pend_target_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

    logic                advance;
    logic                live_redir;
    logic [N_Bits-1:0]   live_target;
    logic                apply_redir;
    logic [N_Bits-1:0]   apply_target;

    // Jump beats branch whenever both resolve together.
    assign live_redir  = jump_i | branch_taken_i;
    assign live_target = jump_i ? jump_target_i : branch_target_target_sel();

    function automatic logic [N_Bits-1:0] branch_target_target_sel();
        return branch_target_i;
    endfunction

    // Live redirect wins over an older pending one.
    assign apply_redir  = live_redir | pend_valid_q;
    assign apply_target = live_redir ? live_target : pend_target_q;

    assign advance = icache_hit_i & ~stall_ext_i;

    always_comb begin
        state_d        = state_q;
        pend_valid_d   = pend_valid_q;
        pend_target_d  = pend_target_q;
        miss_cnt_d     = miss_cnt_q;
        pc_next_o      = pc_i;
        icache_req_o   = 1'b0;
        fetch_valid_o  = 1'b0;
        misalign_err_o = 1'b0;

        case (state_q)
            RUN, MISS: begin
                icache_req_o = 1'b1;
                if (advance) begin
                    fetch_valid_o = 1'b1;
                    pend_valid_d  = 1'b0;
                    state_d       = RUN;
                    if (apply_redir) begin
                        pc_next_o      = {apply_target[N_Bits-1:2], 2'b00};
                        misalign_err_o = |apply_target[1:0];
                    end else begin
                        // modulo 2^N_Bits, wrap is silent
                        pc_next_o = pc_i + N_Bits'(4);
                    end
                end else begin
                    // Hold pc; remember the newest redirect for later.
                    if (live_redir) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = live_target;
                    end
                    if (!icache_hit_i) begin
                        state_d = MISS;
                        // Count a miss once, on entry from RUN.
                        if (state_q == RUN && miss_cnt_q != '1)
                            miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                // BOOT: one cycle, redirects ignored
                pc_next_o = RESET_VECTOR;
                state_d   = RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= BOOT;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            miss_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_pc_fetch_controller.sv
module tb_pc_fetch_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = 32'hDEAD_BEE0;
    logic        hit = 1'b0, stall = 1'b0, br = 1'b0, jmp = 1'b0;
    logic [31:0] br_t = '0, jmp_t = '0;
    logic [31:0] pc_next;
    logic        req, fv, mis;
    logic [15:0] cnt;

    // small-counter instance for saturation
    logic [31:0] pc2 = '0;
    logic        hit2 = 1'b1;
    logic [31:0] pc_next2;
    logic        req2, fv2, mis2;
    logic [1:0]  cnt2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_fetch_controller #(.N_Bits(32), .RESET_VECTOR(32'h0), .CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .pc_i(pc), .icache_hit_i(hit),
        .stall_ext_i(stall), .branch_taken_i(br), .branch_target_i(br_t),
        .jump_i(jmp), .jump_target_i(jmp_t), .pc_next_o(pc_next),
        .icache_req_o(req), .fetch_valid_o(fv), .misalign_err_o(mis),
        .miss_cnt_o(cnt)
    );

    pc_fetch_controller #(.N_Bits(32), .RESET_VECTOR(32'h0), .CNT_W(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .pc_i(pc2), .icache_hit_i(hit2),
        .stall_ext_i(1'b0), .branch_taken_i(1'b0), .branch_target_i(32'h0),
        .jump_i(1'b0), .jump_target_i(32'h0), .pc_next_o(pc_next2),
        .icache_req_o(req2), .fetch_valid_o(fv2), .misalign_err_o(mis2),
        .miss_cnt_o(cnt2)
    );

    // Program_Counter model: no enable
    always_ff @(posedge clk) begin
        pc  <= pc_next;
        pc2 <= pc_next2;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // apply inputs, settle, check combinational outputs
    task automatic drive(input logic h, input logic s, input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt);
        hit = h; stall = s; br = b; br_t = bt; jmp = j; jmp_t = jt;
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] e_pcn, input logic e_fv,
                        input logic e_mis);
        chk({tag, ".pc_next"}, 64'(pc_next), 64'(e_pcn));
        chk({tag, ".fv"},      64'(fv),      64'(e_fv));
        chk({tag, ".mis"},     64'(mis),     64'(e_mis));
    endtask

    initial begin
        // reset
        tick(); tick();
        drive(1, 0, 0, 0, 0, 0);
        chk("rst.pc_next", 64'(pc_next), 64'h0);
        chk("rst.req", 64'(req), 64'h0);
        chk("rst.fv",  64'(fv),  64'h0);
        chk("rst.mis", 64'(mis), 64'h0);
        chk("rst.cnt", 64'(cnt), 64'h0);
        rst_n = 1'b1;
        #1;
        // BOOT
        look("boot", 32'h0, 0, 0);
        chk("boot.req", 64'(req), 64'h0);
        tick();
        chk("run.pc0", 64'(pc), 64'h0);
        chk("run.req", 64'(req), 64'h1);
        look("run0", 32'h4, 1, 0);
        tick(); look("run4", 32'h8, 1, 0);
        tick(); chk("pc8", 64'(pc), 64'h8);
        // miss for 3 cycles at 8
        drive(0, 0, 0, 0, 0, 0); look("miss1", 32'h8, 0, 0);
        chk("miss1.req", 64'(req), 64'h1);
        tick(); chk("miss.cnt1", 64'(cnt), 64'h1);
        look("miss2", 32'h8, 0, 0);
        tick(); look("miss3", 32'h8, 0, 0);
        tick(); chk("miss.cnt_hold", 64'(cnt), 64'h1);
        drive(1, 0, 0, 0, 0, 0); look("resume", 32'hC, 1, 0);
        tick(); chk("pc12", 64'(pc), 64'hC);
        look("run12", 32'h10, 1, 0);
        tick(); chk("pc16", 64'(pc), 64'h10);
        // miss at 0x10 with branch captured
        drive(0, 0, 1, 32'h40, 0, 0); look("mbr", 32'h10, 0, 0);
        tick(); chk("miss.cnt2", 64'(cnt), 64'h2);
        drive(1, 0, 0, 0, 0, 0); look("pend_apply", 32'h40, 1, 0);
        tick(); look("pend_clear", 32'h44, 1, 0);
        tick();
        // jump vs branch
        drive(1, 0, 1, 32'h200, 1, 32'h100); look("jmp_pri", 32'h100, 1, 0);
        tick();
        drive(1, 0, 0, 0, 1, 32'h102); look("jmp_mis", 32'h100, 1, 1);
        tick();
        drive(1, 0, 0, 0, 0, 0); look("mis_1cyc", 32'h104, 1, 0);
        tick();
        // misaligned pending target reports when applied
        drive(1, 1, 0, 0, 1, 32'h203); look("pend_mis_latch", 32'h104, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0); look("pend_mis_apply", 32'h200, 1, 1);
        tick();
        // stall at 0x20
        drive(1, 0, 0, 0, 1, 32'h20); look("to20", 32'h20, 1, 0);
        tick();
        drive(1, 1, 0, 0, 0, 0); look("stall1", 32'h20, 0, 0);
        tick(); look("stall2", 32'h20, 0, 0);
        tick(); chk("stall.cnt", 64'(cnt), 64'h2);
        drive(1, 0, 0, 0, 0, 0); look("unstall", 32'h24, 1, 0);
        tick();
        // wrap
        drive(1, 0, 0, 0, 1, 32'hFFFF_FFFC); look("towrap", 32'hFFFF_FFFC, 1, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0); look("wrap", 32'h0, 1, 0);
        tick();
        // reset mid-miss with pending redirect
        drive(0, 0, 0, 0, 1, 32'h300);
        tick(); chk("pre_rst.cnt", 64'(cnt), 64'h3);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("rst2.pc_next", 64'(pc_next), 64'h0);
        chk("rst2.cnt", 64'(cnt), 64'h0);
        chk("rst2.req", 64'(req), 64'h0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        look("boot2", 32'h0, 0, 0);
        tick(); chk("boot2.pc", 64'(pc), 64'h0);
        look("no_stale", 32'h4, 1, 0);
        tick();
        // saturation on the 2-bit counter instance
        for (int i = 0; i < 4; i++) begin
            hit2 = 1'b0;
            tick();
            hit2 = 1'b1;
            tick();
            if (i == 2) chk("sat.cnt3", 64'(cnt2), 64'h3);
        end
        chk("sat.hold", 64'(cnt2), 64'h3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
